// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo reservation station: operand, dispatch, CDB and issue records.
package tomasulo_pkg;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  tag_t;
  typedef logic [2:0]  op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_AND = 3'd2;
  localparam op_t OP_OR  = 3'd3;
  localparam op_t OP_XOR = 3'd4;

  typedef struct packed {
    logic  rdy;
    tag_t  tag;
    word_t data;
  } src_t;

  typedef struct packed {
    op_t  op;
    tag_t dst;
    src_t src0;
    src_t src1;
  } dispatch_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  typedef struct packed {
    op_t   op;
    tag_t  tag;
    tag_t  dst;
    word_t a;
    word_t b;
  } issue_t;

  // A waiting operand captures the broadcast whose tag it is waiting on.
  function automatic src_t src_wake(input src_t s, input cdb_t c);
    src_t r;
    r = s;
    if (!s.rdy && c.vld && (c.tag == s.tag)) begin
      r.rdy  = 1'b1;
      r.data = c.wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_rs_pick.sv
// Issue picker: one-hot grant among eligible entries; oldest-first with an age matrix when
// TOMASULO_RS_AGE_ORDER_EN is defined, otherwise lowest index. Combinational, no backpressure.
module tomasulo_rs_pick #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] elig,
  output logic [N-1:0] grant
);

`ifdef TOMASULO_RS_AGE_ORDER_EN
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [N-1:0] older_q [N];
  logic [N-1:0] older_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) older_d[i] = older_q[i];
    for (int k = 0; k < N; k++) begin
      if (alloc[k]) begin
        for (int j = 0; j < N; j++) begin
          older_d[k][j] = 1'b0;
          if (j != k) older_d[j][k] = 1'b1;
        end
      end
    end
  end

  // Uses the updated matrix so an entry dispatched this cycle already ranks youngest.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < N; j++) begin
        if ((j != i) && elig[j] && !older_d[i][j]) grant[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) older_q[i] <= older_d[i];
    end
  end
`else
  logic unused_pick;
  assign unused_pick = ^{clk, rst, alloc};

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (grant == '0)) grant[i] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/tomasulo_rs.sv
// Tomasulo reservation station: N entries, CDB wakeup, single registered issue port (exe_r).
// Latency: an entry ready at end of cycle t is on exe_r at t+1; full_r leaves one slot of skid.
// Backpressure: exe_r holds while exe_rdy=0; dispatch with no free entry is dropped.
module tomasulo_rs
  import tomasulo_pkg::*;
#(
  parameter int N     = 4,
  parameter int RS_ID = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      dis_vld_r,
  input  dispatch_t dis_r,
  output logic      full_r,
  input  cdb_t      cdb_r,
  output logic      exe_vld_r,
  output issue_t    exe_r,
  input  logic      exe_rdy
);

  logic [N-1:0] valid_q, valid_d;
  logic [N-1:0] held_q;
  logic [N-1:0] alloc, elig, grant;
  op_t          op_q  [N];
  op_t          op_d  [N];
  tag_t         dst_q [N];
  tag_t         dst_d [N];
  src_t         s0_q  [N];
  src_t         s0_d  [N];
  src_t         s1_q  [N];
  src_t         s1_d  [N];
  logic         fire, stall, full_d;
  int           cnt_d;
  issue_t       issue_d;

  assign fire  = exe_vld_r & exe_rdy;
  assign stall = exe_vld_r & ~exe_rdy;

  // A slot freed this cycle is not offered to dispatch until next cycle.
  always_comb begin
    alloc = '0;
    if (dis_vld_r) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_q[i] && (alloc == '0)) alloc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_d[i]    = op_q[i];
      dst_d[i]   = dst_q[i];
      s0_d[i]    = src_wake(s0_q[i], cdb_r);
      s1_d[i]    = src_wake(s1_q[i], cdb_r);
      valid_d[i] = valid_q[i] & ~(fire & held_q[i]);
      if (alloc[i]) begin
        op_d[i]    = dis_r.op;
        dst_d[i]   = dis_r.dst;
        s0_d[i]    = src_wake(dis_r.src0, cdb_r);
        s1_d[i]    = src_wake(dis_r.src1, cdb_r);
        valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = valid_d[i] & s0_d[i].rdy & s1_d[i].rdy & ~held_q[i];
    end
  end

  tomasulo_rs_pick #(.N(N)) u_pick (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc),
    .elig  (elig),
    .grant (grant)
  );

  always_comb begin
    issue_d = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        issue_d.op  = op_d[i];
        issue_d.tag = tag_t'(RS_ID * 8 + i);
        issue_d.dst = dst_d[i];
        issue_d.a   = s0_d[i].data;
        issue_d.b   = s1_d[i].data;
      end
    end
  end

  always_comb begin
    cnt_d = 0;
    for (int i = 0; i < N; i++) begin
      if (valid_d[i]) cnt_d = cnt_d + 1;
    end
    full_d = (cnt_d >= N - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      held_q    <= '0;
      exe_vld_r <= 1'b0;
      full_r    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      held_q    <= stall ? held_q : grant;
      exe_vld_r <= stall | (|grant);
      full_r    <= full_d;
    end
  end

  // Payload storage carries no reset; valid_q and exe_vld_r qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      op_q[i]  <= op_d[i];
      dst_q[i] <= dst_d[i];
      s0_q[i]  <= s0_d[i];
      s1_q[i]  <= s1_d[i];
    end
    if (!stall) exe_r <= issue_d;
  end

endmodule

// File: tb/tb_tomasulo_rs.sv
// Bench for tomasulo_rs: directed scenarios then random traffic, all checked against a
// sequence-number based reference model (oldest-first when TOMASULO_RS_AGE_ORDER_EN is defined).
module tb_tomasulo_rs;
  import tomasulo_pkg::*;

  localparam int N     = 4;
  localparam int RS_ID = 3;
  localparam int BASE  = RS_ID * 8;

  logic      clk = 1'b0;
  logic      rst;
  logic      dis_vld_r;
  dispatch_t dis_r;
  logic      full_r;
  cdb_t      cdb_r;
  logic      exe_vld_r;
  issue_t    exe_r;
  logic      exe_rdy;

  int total = 0;
  int bad   = 0;

  tomasulo_rs #(.N(N), .RS_ID(RS_ID)) dut (
    .clk       (clk),
    .rst       (rst),
    .dis_vld_r (dis_vld_r),
    .dis_r     (dis_r),
    .full_r    (full_r),
    .cdb_r     (cdb_r),
    .exe_vld_r (exe_vld_r),
    .exe_r     (exe_r),
    .exe_rdy   (exe_rdy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit     m_v   [N];
  op_t    m_op  [N];
  tag_t   m_dst [N];
  src_t   m_s0  [N];
  src_t   m_s1  [N];
  int     m_seq [N];
  int     seq_ctr;
  int     m_held;
  bit     m_exe_vld;
  issue_t m_exe;
  bit     m_full;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic src_t wk(input src_t s);
    src_t r = s;
    if (cdb_r.vld && !s.rdy && s.tag == cdb_r.tag) begin
      r.rdy  = 1'b1;
      r.data = cdb_r.wdata;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_held = -1; m_exe_vld = 1'b0; m_full = 1'b0; seq_ctr = 0;
  endtask

  task automatic model_step();
    bit fire, stall;
    int fi, pick, cnt;
    fire  = m_exe_vld && exe_rdy;
    stall = m_exe_vld && !exe_rdy;
    fi = -1;
    for (int i = 0; i < N; i++) if (!m_v[i] && fi < 0) fi = i;
    if (fire) m_v[m_held] = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_s0[i] = wk(m_s0[i]);
      m_s1[i] = wk(m_s1[i]);
    end
    if (dis_vld_r && fi >= 0) begin
      m_v[fi] = 1'b1; m_op[fi] = dis_r.op; m_dst[fi] = dis_r.dst;
      m_s0[fi] = wk(dis_r.src0); m_s1[fi] = wk(dis_r.src1);
      m_seq[fi] = seq_ctr; seq_ctr++;
    end
    if (!stall) begin
      pick = -1;
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && m_s0[i].rdy && m_s1[i].rdy) begin
`ifdef TOMASULO_RS_AGE_ORDER_EN
          if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
          if (pick < 0) pick = i;
`endif
        end
      end
      m_held    = pick;
      m_exe_vld = (pick >= 0);
      if (pick >= 0) begin
        m_exe.op  = m_op[pick];
        m_exe.tag = tag_t'(BASE + pick);
        m_exe.dst = m_dst[pick];
        m_exe.a   = m_s0[pick].data;
        m_exe.b   = m_s1[pick].data;
      end
    end
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) cnt++;
    m_full = (cnt >= N - 1);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_vld"}, 128'(exe_vld_r), 128'(m_exe_vld));
    check({tag, "_full"}, 128'(full_r), 128'(m_full));
    if (m_exe_vld) check({tag, "_exe"}, 128'(exe_r), 128'(m_exe));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic dispatch(input op_t op, input tag_t dst,
                          input bit r0, input tag_t t0, input word_t d0,
                          input bit r1, input tag_t t1, input word_t d1);
    dis_vld_r = 1'b1;
    dis_r.op = op; dis_r.dst = dst;
    dis_r.src0.rdy = r0; dis_r.src0.tag = t0; dis_r.src0.data = d0;
    dis_r.src1.rdy = r1; dis_r.src1.tag = t1; dis_r.src1.data = d1;
  endtask

  task automatic idle_in();
    dis_vld_r = 1'b0;
    cdb_r     = '0;
  endtask

  task automatic pulse_reset(input string tag);
    idle_in();
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst_vld"}, 128'(exe_vld_r), 128'(0));
    check({tag, "_rst_full"}, 128'(full_r), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dis_vld_r = 1'b0; dis_r = '0; cdb_r = '0; exe_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld", 128'(exe_vld_r), 128'(0));
    check("reset_full", 128'(full_r), 128'(0));
    rst = 1'b0;

    // Both operands ready: issue next cycle, then freed on acceptance.
    exe_rdy = 1'b1;
    dispatch(OP_ADD, 6'd5, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    tick("add");
    check("add_a", 128'(exe_r.a), 128'(32'd5));
    check("add_b", 128'(exe_r.b), 128'(32'd7));
    check("add_tag", 128'(exe_r.tag), 128'(BASE));
    idle_in();
    tick("add_free");
    check("add_gone", 128'(exe_vld_r), 128'(0));

    // Waiting operand woken by the CDB two cycles after dispatch.
    dispatch(OP_SUB, 6'd6, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd3);
    tick("wait0");
    idle_in();
    tick("wait1");
    cdb_r = '{vld: 1'b1, tag: 6'd9, wdata: 32'h1234};
    tick("wake");
    check("wake_a", 128'(exe_r.a), 128'(32'h1234));
    idle_in();
    tick("wake_free");

    // Dispatch and broadcast of the awaited tag in the same cycle.
    dispatch(OP_AND, 6'd7, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'd0);
    cdb_r = '{vld: 1'b1, tag: 6'd9, wdata: 32'hAA};
    tick("bypass");
    check("bypass_b", 128'(exe_r.b), 128'(32'hAA));
    idle_in();
    tick("bypass_free");

    // Fill with exe_rdy low: full after the third, fifth dropped, exe_r stable.
    exe_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dispatch(OP_OR, tag_t'(10 + k), 1'b1, 6'd0, word_t'(100 + k), 1'b1, 6'd0, 32'd0);
      tick("fill");
      check("fill_full", 128'(full_r), 128'(k >= 2));
      check("fill_hold", 128'(exe_r.a), 128'(32'd100));
    end
    idle_in();
    exe_rdy = 1'b1;
    for (int k = 0; k < 6; k++) tick("drain");

    // Reset with three entries and a pending issue.
    exe_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dispatch(OP_XOR, tag_t'(20 + k), 1'b1, 6'd0, word_t'(k), 1'b1, 6'd0, 32'd0);
      tick("pre_rst");
    end
    pulse_reset("mid");
    exe_rdy = 1'b1;
    dispatch(OP_ADD, 6'd30, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9);
    tick("post_rst");
    check("post_rst_tag", 128'(exe_r.tag), 128'(BASE));
    idle_in();
    tick("post_rst_free");

    // Older entry in slot 1, younger in slot 0, woken together.
    exe_rdy = 1'b0;
    dispatch(OP_ADD, 6'd40, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick("age_a");
    dispatch(OP_ADD, 6'd41, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd2);
    tick("age_b");
    idle_in();
    exe_rdy = 1'b1;
    tick("age_fire");
    dispatch(OP_ADD, 6'd42, 1'b1, 6'd0, 32'd3, 1'b0, 6'd12, 32'd0);
    tick("age_c");
    idle_in();
    cdb_r = '{vld: 1'b1, tag: 6'd12, wdata: 32'h55};
    tick("age_wake");
`ifdef TOMASULO_RS_AGE_ORDER_EN
    check("age_pick", 128'(exe_r.tag), 128'(BASE + 1));
`else
    check("age_pick", 128'(exe_r.tag), 128'(BASE));
`endif
    idle_in();
    for (int k = 0; k < 3; k++) tick("age_drain");

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset("rnd");
      dis_vld_r          = ($urandom_range(0, 9) < 6);
      dis_r.op           = op_t'($urandom_range(0, 7));
      dis_r.dst          = tag_t'($urandom_range(0, 63));
      dis_r.src0.rdy     = $urandom_range(0, 1) == 1;
      dis_r.src0.tag     = tag_t'($urandom_range(0, 15));
      dis_r.src0.data    = $urandom;
      dis_r.src1.rdy     = $urandom_range(0, 1) == 1;
      dis_r.src1.tag     = tag_t'($urandom_range(0, 15));
      dis_r.src1.data    = $urandom;
      cdb_r.vld          = $urandom_range(0, 1) == 1;
      cdb_r.tag          = tag_t'($urandom_range(0, 15));
      cdb_r.wdata        = $urandom;
      exe_rdy            = $urandom_range(0, 1) == 1;
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tomasulo_rs.md
TOMASULO_RS -- requirements
Module: tomasulo_rs

Interface
REQ-001 Parameter N, default 4, number of reservation-station entries (2..8).
REQ-002 Parameter RS_ID, default 0, station tag base; entry i owns tag RS_ID*8+i.
REQ-003 clk  input  1  clock; single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dis_vld_r  input  1  dispatch valid from dispatcher (registered there).
REQ-006 dis_r  input  dispatch_t  op, dst tag, src0/src1 {rdy, tag, data}.
REQ-007 full_r  output  1  registered back-pressure to dispatcher.
REQ-008 cdb_r  input  cdb_t  common data bus {vld, tag, wdata}.
REQ-009 exe_vld_r  output  1  issue valid to functional unit.
REQ-010 exe_r  output  issue_t  {op, tag, a, b} of issued entry.
REQ-011 exe_rdy  input  1  functional unit accepts issue this cycle.

Function
REQ-012 Dispatch SHALL write dis_r into the lowest-index free entry on the cycle dis_vld_r=1; the entry is valid from the next cycle.
REQ-013 full_r SHALL be 1 when the valid-entry count after the current cycle is >= N-1, giving one-slot skid for the dispatcher's one-cycle registered path.
REQ-014 dis_vld_r with no free entry SHALL drop the dispatch and leave state unchanged.
REQ-015 cdb_r.vld with tag equal to a valid entry's non-ready source tag SHALL set that source rdy and capture cdb_r.wdata the same cycle, for every matching entry and source.
REQ-016 A dispatch whose source tag matches cdb_r.tag in the same cycle SHALL be written with rdy=1 and data=cdb_r.wdata.
REQ-017 An entry SHALL be issue-eligible when valid, both sources rdy, and not currently held on exe_r.
REQ-018 exe_vld_r/exe_r SHALL be registered; an entry ready at end of cycle t appears on exe_r at t+1.
REQ-019 exe_r SHALL hold stable while exe_vld_r=1 and exe_rdy=0.
REQ-020 exe_vld_r=1 and exe_rdy=1 SHALL free the issued entry and allow a new issue on the following cycle.
REQ-021 Simultaneous issue-free and dispatch SHALL be legal; the freed slot is reusable next cycle.
REQ-022 exe_r.tag SHALL be the entry's own tag; dst field passes through unchanged.

Reset
REQ-023 rst SHALL clear all entry valid bits, full_r=0, exe_vld_r=0; data fields are not reset.
REQ-024 rst asserted mid-operation SHALL discard all entries and any pending issue immediately.

Configuration
REQ-025 Macro TOMASULO_RS_AGE_ORDER_EN defined: among eligible entries, issue the oldest by dispatch order (age matrix).
REQ-026 Macro TOMASULO_RS_AGE_ORDER_EN undefined: issue the lowest-index eligible entry; no age state is built.

Structure
REQ-027 tomasulo_pkg SHALL hold word_t (32b), tag_t (6b), op_t (3b), src_t, dispatch_t, cdb_t, issue_t.
REQ-028 Ready selection SHALL be one sub-module, tomasulo_rs_pick (eligible vector in, one-hot grant out, age matrix under the macro).

Verification
REQ-029 Dispatch op=ADD, both src ready (a=5, b=7), exe_rdy=1 -> exe_vld_r=1 next cycle with a=5, b=7, tag=RS_ID*8+0; entry freed after.
REQ-030 Dispatch src0 waiting tag 9; CDB tag 9 data 0x1234 two cycles later -> issue with a=0x1234 the cycle after the CDB.
REQ-031 Dispatch src1 tag 9 in the same cycle CDB broadcasts tag 9 data 0xAA -> entry ready immediately, issue b=0xAA next cycle.
REQ-032 N=4, exe_rdy=0, four back-to-back dispatches -> full_r=1 after the third is accepted; a fifth dis_vld_r is dropped; exe_r stable.
REQ-033 With age order on, dispatch E0 (waiting), E1 (ready), then wake E0 -> E1 issues first; with macro off and both ready, E0 issues first.
REQ-034 rst pulsed with 3 valid entries and exe_vld_r=1 -> exe_vld_r=0, full_r=0 immediately; next dispatch lands in entry 0.
